// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline sequencer and the datapath/stimulus.
// The datapath side (master) presents the two in-flight instructions and the
// EX branch condition; the sequencer (slave) returns stage enables/clears,
// the run state and the hazard counters.
interface pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [31:0]      ir_id;
    logic [31:0]      ir_ex;
    logic             br_taken;
    logic             pc_we;
    logic             pc_sel;
    logic             if_id_we;
    logic             if_id_clr;
    logic             id_ex_we;
    logic             id_ex_clr;
    logic             ex_mem_we;
    logic             mem_wb_we;
    logic [1:0]       state;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output start, ir_id, ir_ex, br_taken,
        input  pc_we, pc_sel, if_id_we, if_id_clr, id_ex_we, id_ex_clr,
               ex_mem_we, mem_wb_we, state, halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  start, ir_id, ir_ex, br_taken,
        output pc_we, pc_sel, if_id_we, if_id_clr, id_ex_we, id_ex_clr,
               ex_mem_we, mem_wb_we, state, halted, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for a 5-stage MIPS32-style core.
// Holds only control state: run/drain/halt FSM, per-stage valid bits and two
// saturating hazard counters. Stage enables and clears are decoded
// combinationally from that state and the IF/ID and ID/EX instructions, so
// the datapath sees them in the same cycle. Priority: branch flush, then
// load-use bubble, then HLT.
module pipe_ctrl #(
    parameter int OP_W  = 6,
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    pipe_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_DRAIN  = 2'b10,
        ST_HALTED = 2'b11
    } state_t;

    localparam logic [OP_W-1:0] OP_LW  = 6'b100000;
    localparam logic [OP_W-1:0] OP_SW  = 6'b100001;
    localparam logic [OP_W-1:0] OP_HLT = 6'b111111;
    localparam logic [OP_W-2:0] OP_BR  = 5'b11010;   // BEQZ/BNEQZ share op[5:1]

    // Does this opcode read the register in the rs field?
    function automatic logic reads_rs(input logic [OP_W-1:0] op);
        logic r;
        if (op[OP_W-1] == 1'b0) begin
            r = 1'b1;                                  // ALU RR and RImm
        end else if ((op == OP_LW) || (op == OP_SW)) begin
            r = 1'b1;
        end else if (op[OP_W-1:1] == OP_BR) begin
            r = 1'b1;
        end else begin
            r = 1'b0;
        end
        return r;
    endfunction

    // Does this opcode read the register in the rt field? (RImm/LW write rt)
    function automatic logic reads_rt(input logic [OP_W-1:0] op);
        logic r;
        if (op[OP_W-1:OP_W-2] == 2'b00) begin
            r = 1'b1;                                  // ALU RR
        end else if (op == OP_SW) begin
            r = 1'b1;
        end else begin
            r = 1'b0;
        end
        return r;
    endfunction

    state_t           state_r, state_s;
    logic             v_id_r, v_ex_r, v_mem_r, v_wb_r;
    logic             v_id_s, v_ex_s, v_mem_s, v_wb_s;
    logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

    logic [OP_W-1:0]  op_id_s, op_ex_s;
    logic [REG_W-1:0] rs_id_s, rt_id_s, rt_ex_s;
    logic             flush_s, luse_s, hlt_s;

    logic pc_we_s, pc_sel_s, if_id_we_s, if_id_clr_s;
    logic id_ex_we_s, id_ex_clr_s, ex_mem_we_s, mem_wb_we_s;

    assign op_id_s = bus.ir_id[31 -: OP_W];
    assign op_ex_s = bus.ir_ex[31 -: OP_W];
    assign rs_id_s = bus.ir_id[31-OP_W -: REG_W];
    assign rt_id_s = bus.ir_id[31-OP_W-REG_W -: REG_W];
    assign rt_ex_s = bus.ir_ex[31-OP_W-REG_W -: REG_W];

    // Fields the sequencer never looks at (immediates, rd, rs of EX).
    logic unused_fields_s;
    assign unused_fields_s = ^{bus.ir_id[31-OP_W-2*REG_W:0],
                               bus.ir_ex[31-OP_W -: REG_W],
                               bus.ir_ex[31-OP_W-2*REG_W:0]};

    // Hazard decode: only meaningful while running; flush masks the others.
    always_comb begin
        flush_s = 1'b0;
        luse_s  = 1'b0;
        hlt_s   = 1'b0;
        if (state_r == ST_RUN) begin
            flush_s = v_ex_r & bus.br_taken & (op_ex_s[OP_W-1:1] == OP_BR);
            luse_s  = ~flush_s & v_ex_r & v_id_r & (op_ex_s == OP_LW) &
                      (rt_ex_s != {REG_W{1'b0}}) &
                      ((reads_rs(op_id_s) & (rs_id_s == rt_ex_s)) |
                       (reads_rt(op_id_s) & (rt_id_s == rt_ex_s)));
            hlt_s   = ~flush_s & ~luse_s & v_id_r & (op_id_s == OP_HLT);
        end else begin
            flush_s = 1'b0;
            luse_s  = 1'b0;
            hlt_s   = 1'b0;
        end
    end

    // FSM next state, valid-bit shift and stage enables/clears.
    always_comb begin
        state_s     = state_r;
        v_id_s      = v_id_r;
        v_ex_s      = v_ex_r;
        v_mem_s     = v_mem_r;
        v_wb_s      = v_wb_r;
        pc_we_s     = 1'b0;
        pc_sel_s    = 1'b0;
        if_id_we_s  = 1'b0;
        if_id_clr_s = 1'b0;
        id_ex_we_s  = 1'b0;
        id_ex_clr_s = 1'b0;
        ex_mem_we_s = 1'b0;
        mem_wb_we_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                pc_we_s     = ~luse_s & ~hlt_s;
                pc_sel_s    = flush_s;
                if_id_we_s  = ~luse_s;
                if_id_clr_s = flush_s | hlt_s;
                id_ex_we_s  = 1'b1;
                id_ex_clr_s = flush_s | luse_s | hlt_s;
                ex_mem_we_s = 1'b1;
                mem_wb_we_s = 1'b1;
                // A stalled IF/ID keeps its (valid) instruction.
                v_id_s  = ~(flush_s | hlt_s);
                v_ex_s  = v_id_r & ~(flush_s | luse_s | hlt_s);
                v_mem_s = v_ex_r;
                v_wb_s  = v_mem_r;
                if (hlt_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if_id_clr_s = 1'b1;
                id_ex_clr_s = 1'b1;
                ex_mem_we_s = 1'b1;
                mem_wb_we_s = 1'b1;
                v_id_s  = 1'b0;
                v_ex_s  = 1'b0;
                v_mem_s = v_ex_r;
                v_wb_s  = v_mem_r;
                if (v_ex_r | v_mem_r | v_wb_r) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_HALTED;
                end
            end
            ST_HALTED: begin
                state_s = ST_HALTED;
                v_id_s  = 1'b0;
                v_ex_s  = 1'b0;
                v_mem_s = 1'b0;
                v_wb_s  = 1'b0;
            end
            default: begin
                state_s = ST_IDLE;
                v_id_s  = 1'b0;
                v_ex_s  = 1'b0;
                v_mem_s = 1'b0;
                v_wb_s  = 1'b0;
            end
        endcase
    end

    // State and valid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            v_id_r  <= 1'b0;
            v_ex_r  <= 1'b0;
            v_mem_r <= 1'b0;
            v_wb_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            v_id_r  <= v_id_s;
            v_ex_r  <= v_ex_s;
            v_mem_r <= v_mem_s;
            v_wb_r  <= v_wb_s;
        end
    end

    // Saturating hazard counters; flush and stall are mutually exclusive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (luse_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (flush_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
                flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.pc_we     = pc_we_s;
    assign bus.pc_sel    = pc_sel_s;
    assign bus.if_id_we  = if_id_we_s;
    assign bus.if_id_clr = if_id_clr_s;
    assign bus.id_ex_we  = id_ex_we_s;
    assign bus.id_ex_clr = id_ex_clr_s;
    assign bus.ex_mem_we = ex_mem_we_s;
    assign bus.mem_wb_we = mem_wb_we_s;
    assign bus.state     = state_r;
    assign bus.halted    = (state_r == ST_HALTED);
    assign bus.stall_cnt = stall_cnt_r;
    assign bus.flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a cycle model of the sequencing rules
// checked on every negative edge, plus directed literal expectations.
module tb_pipe_ctrl;
    localparam int CNT_W = 16;

    logic clk;
    logic rst_n;

    pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_ctrl #(.OP_W(6), .REG_W(5), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc(input logic [5:0] op, input int rs, input int rt, input int rd);
        logic [4:0] a, b, c;
        a = rs[4:0];
        b = rt[4:0];
        c = rd[4:0];
        return {op, a, b, c, 11'd0};
    endfunction

    // True when instruction ir uses register r as an operand.
    function automatic bit sources(input logic [31:0] ir, input logic [4:0] r);
        logic [5:0] op;
        bit a, b;
        op = ir[31:26];
        a  = (ir[25:21] == r);
        b  = (ir[20:16] == r);
        if (op[5:4] == 2'b00) return a || b;
        if (op[5:4] == 2'b01) return a;
        case (op)
            6'b100000:            return a;
            6'b100001:            return a || b;
            6'b110100, 6'b110101: return a;
            default:              return 1'b0;
        endcase
    endfunction

    // Model state: phase 0 idle / 1 run / 2 drain / 3 halted; occ[0]=ID..[3]=WB.
    int       m_phase, n_phase;
    bit [3:0] m_occ, n_occ;
    int       m_stall, n_stall, m_flush, n_flush;
    bit       e_pc_we, e_pc_sel, e_if_we, e_if_clr, e_ie_we, e_ie_clr, e_em_we, e_mw_we;

    task automatic model_eval();
        bit br, lu, ht;
        {e_pc_we, e_pc_sel, e_if_we, e_if_clr, e_ie_we, e_ie_clr, e_em_we, e_mw_we} = 8'd0;
        n_phase = m_phase;
        n_occ   = m_occ;
        n_stall = m_stall;
        n_flush = m_flush;
        if (m_phase == 0) begin
            if (bus.start) n_phase = 1;
        end else if (m_phase == 1) begin
            br = m_occ[1] && bus.br_taken && (bus.ir_ex[31:27] == 5'b11010);
            lu = !br && m_occ[1] && m_occ[0] && (bus.ir_ex[31:26] == 6'b100000) &&
                 (bus.ir_ex[20:16] != 5'd0) && sources(bus.ir_id, bus.ir_ex[20:16]);
            ht = !br && !lu && m_occ[0] && (bus.ir_id[31:26] == 6'b111111);
            e_pc_we  = !(lu || ht);
            e_pc_sel = br;
            e_if_we  = !lu;
            e_if_clr = br || ht;
            e_ie_we  = 1'b1;
            e_ie_clr = br || lu || ht;
            e_em_we  = 1'b1;
            e_mw_we  = 1'b1;
            n_occ = {m_occ[2], m_occ[1], (br || lu || ht) ? 1'b0 : m_occ[0], !(br || ht)};
            if (br && m_flush < 65535) n_flush = m_flush + 1;
            if (lu && m_stall < 65535) n_stall = m_stall + 1;
            if (ht) n_phase = 2;
        end else if (m_phase == 2) begin
            e_if_clr = 1'b1;
            e_ie_clr = 1'b1;
            e_em_we  = 1'b1;
            e_mw_we  = 1'b1;
            n_occ   = {m_occ[2], m_occ[1], 2'b00};
            n_phase = (m_occ[3:1] != 3'b000) ? 2 : 3;
        end
    endtask

    task automatic compare_all(input bit in_reset);
        chk("pc_we",     bus.pc_we,     in_reset ? 1'b0 : e_pc_we);
        chk("pc_sel",    bus.pc_sel,    in_reset ? 1'b0 : e_pc_sel);
        chk("if_id_we",  bus.if_id_we,  in_reset ? 1'b0 : e_if_we);
        chk("if_id_clr", bus.if_id_clr, in_reset ? 1'b0 : e_if_clr);
        chk("id_ex_we",  bus.id_ex_we,  in_reset ? 1'b0 : e_ie_we);
        chk("id_ex_clr", bus.id_ex_clr, in_reset ? 1'b0 : e_ie_clr);
        chk("ex_mem_we", bus.ex_mem_we, in_reset ? 1'b0 : e_em_we);
        chk("mem_wb_we", bus.mem_wb_we, in_reset ? 1'b0 : e_mw_we);
        chk("state",     bus.state,     in_reset ? 32'd0 : 32'(m_phase));
        chk("halted",    bus.halted,    (!in_reset && m_phase == 3) ? 1'b1 : 1'b0);
        chk("stall_cnt", bus.stall_cnt, in_reset ? 32'd0 : 32'(m_stall));
        chk("flush_cnt", bus.flush_cnt, in_reset ? 32'd0 : 32'(m_flush));
    endtask

    // Per-cycle compare against the model, advancing it on each rising edge.
    initial begin
        bit have_nxt;
        m_phase = 0; m_occ = 4'd0; m_stall = 0; m_flush = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_phase = 0; m_occ = 4'd0; m_stall = 0; m_flush = 0;
                have_nxt = 1'b0;
                compare_all(1'b1);
            end else begin
                model_eval();
                compare_all(1'b0);
                have_nxt = 1'b1;
            end
            @(posedge clk);
            if (rst_n && have_nxt) begin
                m_phase = n_phase; m_occ = n_occ; m_stall = n_stall; m_flush = n_flush;
            end
        end
    end

    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [31:0] HLT = 32'hFC00_0000;

    typedef struct {
        logic [31:0] ex;
        logic [31:0] id;
        logic        br;
    } vec_t;

    vec_t vecs[$];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ex, input logic [31:0] id, input logic br);
        bus.ir_ex    = ex;
        bus.ir_id    = id;
        bus.br_taken = br;
    endtask

    task automatic fill(input int n);
        drive(NOP, NOP, 1'b0);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Directed stimulus with literal expectations.
    initial begin
        int n;
        rst_n = 1'b0;
        bus.start = 1'b0;
        drive(NOP, NOP, 1'b0);
        cyc(); cyc();
        chk("rst_state", bus.state, 2'b00);
        chk("rst_pc_we", bus.pc_we, 1'b0);

        // Start pulse.
        rst_n = 1'b1;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        #1;
        chk("start_state", bus.state, 2'b01);
        chk("start_pc_we", bus.pc_we, 1'b1);
        chk("start_pc_sel", bus.pc_sel, 1'b0);
        fill(4);

        // Load-use: EX LW r3,0(r1); ID ADD r4,r3,r2.
        drive(enc(6'b100000, 1, 3, 0), enc(6'b000000, 3, 2, 4), 1'b0);
        #1;
        chk("lu_pc_we", bus.pc_we, 1'b0);
        chk("lu_if_id_we", bus.if_id_we, 1'b0);
        chk("lu_id_ex_clr", bus.id_ex_clr, 1'b1);
        cyc();
        drive(NOP, enc(6'b000000, 3, 2, 4), 1'b0);
        #1;
        chk("lu_after_pc_we", bus.pc_we, 1'b1);
        chk("lu_stall_cnt", bus.stall_cnt, 16'd1);
        cyc();

        // Same with r0 as the load target: no stall.
        drive(enc(6'b100000, 1, 0, 0), enc(6'b000000, 0, 2, 4), 1'b0);
        #1;
        chk("r0_pc_we", bus.pc_we, 1'b1);
        chk("r0_id_ex_clr", bus.id_ex_clr, 1'b0);
        cyc();
        #1;
        chk("r0_stall_cnt", bus.stall_cnt, 16'd1);

        // Taken BEQZ r5 in EX.
        drive(enc(6'b110100, 5, 0, 0), NOP, 1'b1);
        #1;
        chk("br_pc_sel", bus.pc_sel, 1'b1);
        chk("br_if_id_clr", bus.if_id_clr, 1'b1);
        chk("br_id_ex_clr", bus.id_ex_clr, 1'b1);
        cyc();
        #1;
        chk("br_flush_cnt", bus.flush_cnt, 16'd1);
        chk("br_nov_pc_sel", bus.pc_sel, 1'b0);   // EX now invalid
        cyc();
        #1;
        chk("br_nov_flush_cnt", bus.flush_cnt, 16'd1);
        fill(2);

        // Table of hazard patterns, each followed by refill cycles.
        vecs.push_back('{enc(6'b100000, 1, 7, 0), enc(6'b010000, 7, 8, 0), 1'b0}); // RImm rs dep: stall
        vecs.push_back('{enc(6'b100000, 1, 7, 0), enc(6'b010000, 2, 7, 0), 1'b0}); // RImm writes rt: none
        vecs.push_back('{enc(6'b100000, 1, 9, 0), enc(6'b100001, 1, 9, 0), 1'b0}); // SW rt dep: stall
        vecs.push_back('{enc(6'b100000, 1, 9, 0), enc(6'b110101, 9, 0, 0), 1'b0}); // BNEQZ dep: stall
        vecs.push_back('{enc(6'b100000, 1, 9, 0), enc(6'b100000, 9, 10, 0), 1'b0}); // LW base dep: stall
        vecs.push_back('{enc(6'b100000, 1, 9, 0), enc(6'b000000, 1, 2, 9), 1'b0}); // rd only: none
        vecs.push_back('{enc(6'b100001, 1, 3, 0), enc(6'b000000, 3, 2, 4), 1'b0}); // SW in EX: none
        vecs.push_back('{enc(6'b110101, 5, 0, 0), enc(6'b000000, 3, 2, 4), 1'b1}); // BNEQZ taken: flush
        vecs.push_back('{enc(6'b110100, 5, 0, 0), HLT, 1'b1});                       // flush beats HLT
        vecs.push_back('{enc(6'b000000, 1, 2, 3), NOP, 1'b1});                       // not a branch
        foreach (vecs[i]) begin
            drive(vecs[i].ex, vecs[i].id, vecs[i].br);
            cyc();
            fill(2);
        end
        chk("tbl_state", bus.state, 2'b01);
        chk("tbl_stall_cnt", bus.stall_cnt, 16'd5);
        chk("tbl_flush_cnt", bus.flush_cnt, 16'd3);

        // HLT, then reset in the middle of the drain.
        drive(NOP, HLT, 1'b0);
        #1;
        chk("hlt_pc_we", bus.pc_we, 1'b0);
        chk("hlt_if_id_clr", bus.if_id_clr, 1'b1);
        chk("hlt_id_ex_clr", bus.id_ex_clr, 1'b1);
        cyc();
        drive(NOP, NOP, 1'b0);
        chk("hlt_state", bus.state, 2'b10);
        cyc();
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", bus.state, 2'b00);
        chk("mid_rst_ex_mem_we", bus.ex_mem_we, 1'b0);
        chk("mid_rst_id_ex_clr", bus.id_ex_clr, 1'b0);
        chk("mid_rst_stall_cnt", bus.stall_cnt, 16'd0);
        chk("mid_rst_flush_cnt", bus.flush_cnt, 16'd0);
        cyc();

        // Restart, fill the pipe, then a full drain to HALTED.
        rst_n = 1'b1;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        fill(4);
        drive(NOP, HLT, 1'b0);
        cyc();
        drive(NOP, NOP, 1'b0);
        n = 0;
        while (bus.state == 2'b10 && n < 10) begin
            n++;
            cyc();
        end
        chk("drain_cycles", n, 3);
        chk("halted", bus.halted, 1'b1);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        cyc();
        chk("halted_sticky_state", bus.state, 2'b11);
        chk("halted_pc_we", bus.pc_we, 1'b0);
        chk("halted_mem_wb_we", bus.mem_wb_we, 1'b0);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
